// File: rtl/spi_pkg.sv
// Shared SPI constants: opcodes, master FSM encoding and slave state names.
// Optional build macro used by the master: SPI_MASTER_AUTO_READ_EN.
package spi_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TURN  = 3'd3,
    ST_READ  = 3'd4,
    ST_GAP   = 3'd5
  } spi_mst_state_t;

  typedef enum logic [2:0] {
    SL_CHK_CMD   = 3'd1,
    SL_READ_ADD  = 3'd2,
    SL_READ_DATA = 3'd3,
    SL_WRITE     = 3'd4
  } spi_slv_state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// Parallel-load/serial-out command register plus serial-in read-back register.
module spi_master_shifter #(
  parameter int WORD_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_load_word,
  input  logic              i_shift,
  input  logic              i_cap,
  input  logic              i_miso,
  output logic              o_tx_hi,
  output logic              o_tx_next,
  output logic [DATA_W-1:0] o_rx_next
);

  logic [WORD_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;

  assign o_tx_hi   = r_tx[WORD_W-1];
  assign o_tx_next = r_tx[WORD_W-2];
  assign o_rx_next = {r_rx[DATA_W-2:0], i_miso};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx <= '0;
      r_rx <= '0;
    end else begin
      if (i_load)
        r_tx <= i_load_word;
      else if (i_shift)
        r_tx <= {r_tx[WORD_W-2:0], 1'b0};
      if (i_cap)
        r_rx <= o_rx_next;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises a 10-bit command, optionally reads back one byte.
// Build macro SPI_MASTER_AUTO_READ_EN chains a read-data frame after each read-addr frame.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int WORD_W  = 10,
  parameter int DATA_W  = 8,
  parameter int TA_CYC  = 1,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] tx_word,
  output logic              ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [CNT_W-1:0] L_SHIFT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] L_TURN  = CNT_W'(TA_CYC - 1);
  localparam logic [CNT_W-1:0] L_READ  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(GAP_CYC - 1);

  spi_mst_state_t    r_state, w_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_op;
  logic              r_ss_n, r_mosi, r_done, r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_load, w_mosi_nxt, w_done_nxt, w_rdv_nxt;
  logic [WORD_W-1:0] w_load_word;
  logic              w_tx_hi, w_tx_next;
  logic [DATA_W-1:0] w_rx_next;

  spi_master_shifter #(.WORD_W(WORD_W), .DATA_W(DATA_W)) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_word (w_load_word),
    .i_shift     (r_state == ST_SHIFT),
    .i_cap       (r_state == ST_READ),
    .i_miso      (MISO),
    .o_tx_hi     (w_tx_hi),
    .o_tx_next   (w_tx_next),
    .o_rx_next   (w_rx_next)
  );

  always_comb begin
    w_nxt       = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
    w_load      = 1'b0;
    w_load_word = tx_word;
    w_mosi_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_rdv_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_nxt      = ST_CMD;
        w_cnt_nxt  = '0;
        w_load     = 1'b1;
        w_mosi_nxt = tx_word[WORD_W-1];
      end
      ST_CMD: begin
        w_mosi_nxt = w_tx_hi;
        if (r_cnt == '0) begin
          w_nxt     = ST_SHIFT;
          w_cnt_nxt = L_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_mosi_nxt = w_tx_next;
        if (r_cnt == '0) begin
          w_mosi_nxt = 1'b0;
          if (r_op == OP_RD_DATA) begin
            w_nxt     = ST_TURN;
            w_cnt_nxt = L_TURN;
          end else begin
            w_nxt     = ST_GAP;
            w_cnt_nxt = L_GAP;
`ifdef SPI_MASTER_AUTO_READ_EN
            w_done_nxt = (r_op != OP_RD_ADDR);
`else
            w_done_nxt = 1'b1;
`endif
          end
        end
      end
      ST_TURN: if (r_cnt == '0) begin
        w_nxt     = ST_READ;
        w_cnt_nxt = L_READ;
      end
      ST_READ: if (r_cnt == '0) begin
        w_nxt      = ST_GAP;
        w_cnt_nxt  = L_GAP;
        w_rdv_nxt  = 1'b1;
        w_done_nxt = 1'b1;
      end
      ST_GAP: if (r_cnt == '0) begin
`ifdef SPI_MASTER_AUTO_READ_EN
        if (r_op == OP_RD_ADDR) begin
          // Chained read-data frame skips IDLE so the host never sees ready.
          w_nxt       = ST_CMD;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
          w_load_word = {OP_RD_DATA, {(WORD_W-2){1'b0}}};
          w_mosi_nxt  = 1'b1;
        end else begin
          w_nxt = ST_IDLE;
        end
`else
        w_nxt = ST_IDLE;
`endif
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op       <= OP_WR_ADDR;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ss_n     <= (w_nxt == ST_IDLE) || (w_nxt == ST_GAP);
      r_mosi     <= w_mosi_nxt;
      r_done     <= w_done_nxt;
      r_rd_valid <= w_rdv_nxt;
      if (w_load)
        r_op <= w_load_word[WORD_W-1:WORD_W-2];
      if (w_rdv_nxt)
        r_rd_data <= w_rx_next;
    end
  end

  assign ready    = (r_state == ST_IDLE);
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign done     = r_done;
  assign SS_n     = r_ss_n;
  assign MOSI     = r_mosi;

endmodule
